// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Requester-side bundle for the nibble-serial add/sub sequencer:
// operand pair, Start/Ready handshake and the registered results.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Handshake: an operation is accepted on a rising clock edge where
  // Start=1 and Ready=1; Sub/OpA/OpB are sampled on that same edge.
  logic         Start;
  logic         Sub;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic         Ready;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         CarryOut;
  logic         Overflow;

  modport master (
    output Start, Sub, OpA, OpB,
    input  Ready, Busy, Done, Result, CarryOut, Overflow
  );

  modport slave (
    input  Start, Sub, OpA, OpB,
    output Ready, Busy, Done, Result, CarryOut, Overflow
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Wide add/subtract built from one 4-bit slice, one nibble per clock, LSB first,
// with the inter-nibble carry registered; results are published with a Done pulse.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                         Clk,
  input  logic                         ResetN,
  nibble_serial_addsub_ctrl_if.slave   bus,
  output logic [1:0]                   state_dbg
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   part_q, part_d;
  logic [W-1:0]   result_q, result_d;
  logic           sub_q, sub_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic           accept;
  logic           last_nib;
  logic [3:0]     b_x;
  logic [4:0]     sum5;
  logic [3:0]     low4;
  logic           c3;
  logic [W-1:0]   assembled;

  // State register
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.Start) state_d = S_RUN;
      S_RUN:  if (last_nib)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    bus.Ready    = (state_q == S_IDLE);
    bus.Busy     = (state_q != S_IDLE);
    bus.Done     = (state_q == S_DONE);
    bus.Result   = result_q;
    bus.CarryOut = cout_q;
    bus.Overflow = ovf_q;
    state_dbg    = state_q;
  end

  assign accept   = (state_q == S_IDLE) && bus.Start;
  assign last_nib = (idx_q == IDX_LAST);

  // The 4-bit slice; operand registers shift right so nibble 0 is always current.
  // c3 (carry into the slice MSB) is only meaningful on the top nibble, for Overflow.
  always_comb begin
    b_x       = b_q[3:0] ^ {4{sub_q}};
    sum5      = {1'b0, a_q[3:0]} + {1'b0, b_x} + {4'b0000, carry_q};
    low4      = {1'b0, a_q[2:0]} + {1'b0, b_x[2:0]} + {3'b000, carry_q};
    c3        = low4[3];
    assembled = {sum5[3:0], part_q[W-1:4]};
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    result_d = result_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    if (accept) begin
      a_d     = bus.OpA;
      b_d     = bus.OpB;
      sub_d   = bus.Sub;
      carry_d = bus.Sub;
      idx_d   = '0;
      part_d  = '0;
    end else if (state_q == S_RUN) begin
      a_d     = a_q >> 4;
      b_d     = b_q >> 4;
      carry_d = sum5[4];
      idx_d   = idx_q + IW'(1);
      part_d  = assembled;
      if (last_nib) begin
        result_d = assembled;
        cout_d   = sum5[4];
        ovf_d    = sum5[4] ^ c3;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      result_q <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      result_q <= result_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: doc/nibble_serial_addsub_ctrl.md
# nibble_serial_addsub_ctrl

Sequencer that performs a wide add or subtract by time-multiplexing a single 4-bit adder/subtractor slice, one nibble per clock, least significant nibble first, with the carry registered between nibbles. It sits between a requester issuing operand pairs through a Start/Ready handshake and the 4-bit add/sub datapath, which is instantiated inside the block. It returns the full-width result, final carry and signed overflow with a one-cycle Done pulse.

## Interface
- NIBBLES, 4: operand width in nibbles; W = 4*NIBBLES bits; legal range 2..8.
- Clk  input  1  rising-edge clock.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  request; accepted only on a rising edge where Start=1 and Ready=1.
- Sub  input  1  0: OpA+OpB; 1: OpA-OpB. Sampled with Start.
- OpA  input  W  first operand, sampled on acceptance.
- OpB  input  W  second operand, sampled on acceptance.
- Ready  output  1  high only in IDLE.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse; Result, CarryOut and Overflow are valid from this cycle.
- Result  output  W  OpA+OpB or OpA-OpB, modulo 2^W.
- CarryOut  output  1  final carry out of the MSB nibble. For Sub=1, 1 means no borrow (OpA>=OpB unsigned).
- Overflow  output  1  two's-complement overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: Ready=1. On acceptance, latch OpA, OpB and Sub, set the carry register to Sub, clear the nibble index, and go to RUN.
- RUN: each edge computes {c,s} = a_nib + (b_nib XOR {4{Sub}}) + carry for nibble[index].
  - s is shifted into the partial-result register from the MSB side.
  - carry <= c; index <= index+1.
  - On the edge processing index = NIBBLES-1:
    - Result <= the full assembled word.
    - CarryOut <= c.
    - Overflow <= c XOR (carry into bit W-1), where the bit-3 carry is taken inside the slice.
    - Go to DONE.
- DONE: Done=1 for exactly one cycle, then return to IDLE unconditionally.
- Start during RUN or DONE is ignored; no queuing. The requester must hold Start until it sees Ready.
- Changes to OpA, OpB or Sub after acceptance have no effect on the operation in flight.
- Result, CarryOut and Overflow hold their values until the next completion. They are never updated mid-operation.
- Reset (ResetN=0, any state, including mid-RUN):
  - Forces IDLE immediately.
  - Clears Result, CarryOut, Overflow, Done, Busy, the index, the carry register and the operand registers to 0.
  - Ready=1 while in reset.
  - The aborted operation produces no Done.

## Timing
- Acceptance edge = edge 0.
- Nibble i is processed at edge i+1.
- Final results are registered at edge NIBBLES.
- Done is high in the cycle between edge NIBBLES and edge NIBBLES+1.
- Ready returns after edge NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles. Latency from Start to Done is NIBBLES+1 edges (5 for the default).
- Ready, Busy and Done are decoded from registered state only. There is no combinational path from the inputs to any output.
- Carry between nibbles is always registered. The only combinational carry chain is the 4-bit slice.

## Test plan
- Reset, then Start with OpA=16'h1234, OpB=16'h0F0F, Sub=0 -> Done 5 edges after acceptance; Result=16'h2143, CarryOut=0, Overflow=0; Ready=0 for cycles 1..5.
- OpA=16'h0000, OpB=16'h0001, Sub=1 -> Result=16'hFFFF, CarryOut=0 (borrow), Overflow=0.
- Signed and carry boundaries:
  - 16'h7FFF + 16'h0001 -> Result=16'h8000, Overflow=1, CarryOut=0.
  - 16'hFFFF + 16'h0001 -> Result=16'h0000, CarryOut=1, Overflow=0.
  - 16'h8000 - 16'h0001 -> Result=16'h7FFF, Overflow=1, CarryOut=1.
- Accept 16'h0005+16'h0002, then pulse Start with new operands during RUN and during DONE -> those pulses are ignored; a single Done with Result=16'h0007; the next operation is accepted only once Ready=1.
- Deassert ResetN asynchronously after edge 2 of an operation -> outputs go to 0 and Ready=1 immediately, with no Done. A fresh 16'h0003+16'h0007 then completes with Result=16'h000A.
- Back-to-back: hold Start high with 20 random operand pairs and random Sub -> each Result, CarryOut and Overflow matches a reference model, with exactly NIBBLES+2 cycles between successive Done pulses.
